// File: rtl/ddr_wr_pack32_if.sv
// Byte-in / word-out bus of the DDR write packer, plus its status outputs.
interface ddr_wr_pack32_if #(
    parameter int unsigned FIFO_AW = 4
) ();
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               word_valid;
    logic [31:0]        word_data;
    logic               word_ready;
    logic [23:0]        word_cnt;
    logic               frame_done;
    logic               overflow;
    logic               partial_drop;
    logic [FIFO_AW:0]   fifo_level;

    modport slave (
        input  byte_valid, byte_data, word_ready,
        output word_valid, word_data, word_cnt, frame_done, overflow,
               partial_drop, fifo_level
    );

    modport master (
        output byte_valid, byte_data, word_ready,
        input  word_valid, word_data, word_cnt, frame_done, overflow,
               partial_drop, fifo_level
    );
endinterface

// File: rtl/ddr_wr_pack32.sv
// Packs a byte stream LSB-first into 32-bit words, queues them in a FWFT FIFO
// and counts words accepted by the DDR write port per frame.
module ddr_wr_pack32 #(
    parameter logic [23:0] H_PIXEL     = 24'd640,
    parameter logic [23:0] V_PIXEL     = 24'd480,
    parameter logic [19:0] TIMEOUT_CYC = 20'd50000,
    parameter int unsigned FIFO_AW     = 4
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    ddr_wr_pack32_if.slave  bus
);
    localparam int unsigned      DEPTH     = 2 ** FIFO_AW;
    localparam logic [23:0]      FRAME_LEN = 24'(H_PIXEL * V_PIXEL);
    localparam logic [23:0]      CNT_LAST  = FRAME_LEN - 24'd1;
    localparam logic [19:0]      IDLE_LAST = TIMEOUT_CYC - 20'd1;
    localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW + 1)'(DEPTH);

    logic [1:0]         pack_cnt_q, pack_cnt_d;
    logic [23:0]        shreg_q, shreg_d;
    logic [19:0]        idle_q, idle_d;
    logic [FIFO_AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [23:0]        word_cnt_q, word_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q, overflow_d;
    logic               partial_drop_q, partial_drop_d;
    logic [31:0]        mem_q [DEPTH];

    logic [FIFO_AW:0]   level;
    logic               full, pop, push_req, push;
    logic [31:0]        new_word;

    always_comb begin
        level    = wptr_q - rptr_q;
        full     = (level == FULL_LVL);
        pop      = (level != '0) & bus.word_ready;
        push_req = bus.byte_valid & (pack_cnt_q == 2'd3);
        // A full FIFO still takes the word when the head leaves on the same edge.
        push     = push_req & (~full | pop);
        new_word = {bus.byte_data, shreg_q};

        pack_cnt_d     = pack_cnt_q;
        shreg_d        = shreg_q;
        idle_d         = idle_q;
        partial_drop_d = 1'b0;
        if (bus.byte_valid) begin
            pack_cnt_d = pack_cnt_q + 2'd1;
            idle_d     = '0;
            case (pack_cnt_q)
                2'd0:    shreg_d[7:0]   = bus.byte_data;
                2'd1:    shreg_d[15:8]  = bus.byte_data;
                2'd2:    shreg_d[23:16] = bus.byte_data;
                default: ;
            endcase
        end else if (pack_cnt_q != 2'd0) begin
            if (idle_q == IDLE_LAST) begin
                pack_cnt_d     = '0;
                idle_d         = '0;
                partial_drop_d = 1'b1;
            end else begin
                idle_d = idle_q + 20'd1;
            end
        end else begin
            idle_d = '0;
        end

        wptr_d = wptr_q;
        if (push) wptr_d = wptr_q + 1'b1;
        rptr_d = rptr_q;
        if (pop) rptr_d = rptr_q + 1'b1;
        overflow_d = overflow_q | (push_req & ~push);

        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        if (pop) begin
            if (word_cnt_q == CNT_LAST) begin
                word_cnt_d   = '0;
                frame_done_d = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + 24'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pack_cnt_q     <= '0;
            shreg_q        <= '0;
            idle_q         <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            word_cnt_q     <= '0;
            frame_done_q   <= 1'b0;
            overflow_q     <= 1'b0;
            partial_drop_q <= 1'b0;
        end else begin
            pack_cnt_q     <= pack_cnt_d;
            shreg_q        <= shreg_d;
            idle_q         <= idle_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            word_cnt_q     <= word_cnt_d;
            frame_done_q   <= frame_done_d;
            overflow_q     <= overflow_d;
            partial_drop_q <= partial_drop_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wptr_q[FIFO_AW-1:0]] <= new_word;
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign bus.word_valid   = (level != '0);
    assign bus.word_data    = (level != '0) ? mem_q[rptr_q[FIFO_AW-1:0]] : '0;
    assign bus.word_cnt     = word_cnt_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.overflow     = overflow_q;
    assign bus.partial_drop = partial_drop_q;
    assign bus.fifo_level   = level;
endmodule

// File: tb/tb_ddr_wr_pack32.sv
// Randomised and directed bench for ddr_wr_pack32 with a queue-based reference model.
module tb_ddr_wr_pack32;
    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;
    localparam int          TMO   = 20;
    localparam int          FRAME = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    ddr_wr_pack32_if #(.FIFO_AW(AW)) bus ();

    ddr_wr_pack32 #(
        .H_PIXEL    (24'd4),
        .V_PIXEL    (24'd2),
        .TIMEOUT_CYC(20'd20),
        .FIFO_AW    (AW)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [7:0]  pb[$];
    int          m_lvl, m_idle, m_wcnt;
    bit          m_ovf, m_fd, m_pd;
    int          fd_seen, pd_seen;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        pb.delete();
        m_lvl = 0; m_idle = 0; m_wcnt = 0;
        m_ovf = 0; m_fd = 0; m_pd = 0;
    endfunction

    function automatic void model_step(bit bv, logic [7:0] bd, bit rdy);
        bit pop;
        logic [31:0] w;
        pop  = rdy && (m_lvl > 0);
        m_fd = 0;
        m_pd = 0;
        if (pop) begin
            m_wcnt++;
            if (m_wcnt == FRAME) begin
                m_wcnt = 0;
                m_fd   = 1;
            end
        end
        if (bv) begin
            pb.push_back(bd);
            m_idle = 0;
            if (pb.size() == 4) begin
                w = {pb[3], pb[2], pb[1], pb[0]};
                pb.delete();
                if (m_lvl < DEPTH || pop) begin
                    exp_q.push_back(w);
                    m_lvl++;
                end else begin
                    m_ovf = 1;
                end
            end
        end else if (pb.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                pb.delete();
                m_idle = 0;
                m_pd   = 1;
            end
        end
        if (pop) m_lvl--;
    endfunction

    // Monitor: inputs change just after posedge, so at negedge they show the upcoming transfer.
    always @(negedge clk) begin
        if (rst_n && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL spurious_word: got %h, no word expected at %0t", bus.word_data, $time);
            end else begin
                check("word_data", bus.word_data, exp_q.pop_front());
            end
        end
    end

    task automatic check_status();
        check("word_valid",   bus.word_valid,   m_lvl != 0);
        check("fifo_level",   bus.fifo_level,   m_lvl);
        check("word_cnt",     bus.word_cnt,     m_wcnt);
        check("overflow",     bus.overflow,     m_ovf);
        check("frame_done",   bus.frame_done,   m_fd);
        check("partial_drop", bus.partial_drop, m_pd);
        if (bus.frame_done === 1'b1) fd_seen++;
        if (bus.partial_drop === 1'b1) pd_seen++;
    endtask

    task automatic cycle(bit bv, logic [7:0] bd, bit rdy);
        @(posedge clk);
        #1;
        check_status();
        bus.byte_valid = bv;
        bus.byte_data  = bd;
        bus.word_ready = rdy;
        model_step(bv, bd, rdy);
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), rdy);
    endtask

    task automatic send_word(logic [31:0] w, bit rdy);
        for (int k = 0; k < 4; k++) cycle(1'b1, w[8*k +: 8], rdy);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.word_ready = 1'b0;
        #1;
        check("rst_word_valid",   bus.word_valid,   0);
        check("rst_word_data",    bus.word_data,    0);
        check("rst_word_cnt",     bus.word_cnt,     0);
        check("rst_frame_done",   bus.frame_done,   0);
        check("rst_overflow",     bus.overflow,     0);
        check("rst_partial_drop", bus.partial_drop, 0);
        check("rst_fifo_level",   bus.fifo_level,   0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pd0;
        bit bv, rdy;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.word_ready = 1'b0;
        fd_seen = 0;
        pd_seen = 0;
        #2;
        do_reset();

        // First word latency and content
        cycle(1'b1, 8'h11, 1'b1);
        cycle(1'b1, 8'h22, 1'b1);
        cycle(1'b1, 8'h33, 1'b1);
        cycle(1'b1, 8'h44, 1'b1);
        idle(3, 1'b1);
        check("t1_word_cnt", bus.word_cnt, 1);

        // Fill to full, then overflow on the 17th word, then drain
        do_reset();
        for (int i = 0; i < 16; i++) send_word($urandom, 1'b0);
        idle(1, 1'b0);
        check("t2_level_full", bus.fifo_level, 16);
        check("t2_no_overflow", bus.overflow, 0);
        send_word(32'hDEADBEEF, 1'b0);
        idle(1, 1'b0);
        check("t2_overflow", bus.overflow, 1);
        check("t2_level_still_full", bus.fifo_level, 16);
        idle(20, 1'b1);

        // Push into a full FIFO on the same edge as a pop
        do_reset();
        for (int i = 0; i < 16; i++) send_word($urandom, 1'b0);
        cycle(1'b1, 8'h01, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        cycle(1'b1, 8'h04, 1'b1);
        idle(1, 1'b0);
        check("t3_level", bus.fifo_level, 16);
        check("t3_no_overflow", bus.overflow, 0);
        idle(20, 1'b1);

        // Partial word abandoned on timeout
        pd0 = pd_seen;
        cycle(1'b1, 8'h5A, 1'b1);
        cycle(1'b1, 8'hA5, 1'b1);
        idle(TMO, 1'b1);
        send_word(32'hDDCCBBAA, 1'b1);
        idle(3, 1'b1);
        check("t4_drop_pulses", pd_seen - pd0, 1);

        // Frame boundary: 9 words with a frame of 8
        do_reset();
        fd_seen = 0;
        for (int i = 0; i < 9; i++) send_word($urandom, 1'b1);
        idle(3, 1'b1);
        check("t5_frame_pulses", fd_seen, 1);
        check("t5_word_cnt", bus.word_cnt, 1);

        // Reset with words queued and a word half-built
        for (int i = 0; i < 5; i++) send_word($urandom, 1'b0);
        cycle(1'b1, 8'h77, 1'b0);
        cycle(1'b1, 8'h88, 1'b0);
        cycle(1'b1, 8'h99, 1'b0);
        idle(1, 1'b0);
        do_reset();
        send_word(32'h0C0B0A09, 1'b1);
        idle(3, 1'b1);
        check("t6_word_cnt", bus.word_cnt, 1);
        check("t6_level", bus.fifo_level, 0);

        // Random traffic with backpressure phases and idle gaps
        do_reset();
        for (int i = 0; i < 900; i++) begin
            if ((i % 150) >= 115) bv = 1'b0;
            else bv = ($urandom_range(0, 99) < 65);
            if ((i % 150) < 45) rdy = ($urandom_range(0, 3) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            cycle(bv, 8'($urandom), rdy);
        end
        idle(30, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ddr_wr_pack32.md
Name: ddr_wr_pack32

Overview:
Downstream of the UART receive/write stage. Packs the 8-bit write stream (one byte per strobe) into 32-bit pixel words. Buffers the words in a small FIFO and presents them to the DDR3 write port with a valid/ready handshake. Counts accepted words per frame (H_PIXEL*V_PIXEL words) and flags frame completion, FIFO overflow and abandoned partial words.

Parameters:
H_PIXEL, 24'd640, horizontal pixels per frame
V_PIXEL, 24'd480, vertical pixels per frame; frame length = H_PIXEL*V_PIXEL words
TIMEOUT_CYC, 20'd50000, idle sys_clk cycles after which a partial word is discarded
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
byte_valid  input  1  single-cycle strobe: byte_data is valid this cycle
byte_data  input  8  incoming byte, first byte of a word = least significant
word_valid  output  1  FIFO head word available
word_data  output  32  FIFO head word
word_ready  input  1  DDR write side accepts word_data this cycle
word_cnt  output  24  words accepted in current frame
frame_done  output  1  one-cycle pulse when last word of a frame is accepted
overflow  output  1  sticky: a completed word was dropped because the FIFO was full
partial_drop  output  1  one-cycle pulse: partial word discarded on timeout
fifo_level  output  FIFO_AW+1  words currently held

Behaviour:
- Reset (async, sys_rst_n=0): pack_cnt=0, shift reg=0, FIFO empty, word_valid=0, word_data=0, word_cnt=0, frame_done=0, overflow=0, partial_drop=0, fifo_level=0, idle counter=0. Reset mid-word or mid-frame discards everything. No state survives.
- Packing: byte k (k=0..3) of a word goes to bits [8k+7:8k]. pack_cnt is a 2-bit counter and increments on each byte_valid. When byte_valid arrives with pack_cnt=3, the assembled word is pushed into the FIFO on the same clock edge and pack_cnt wraps to 0.
- Latency: 4th byte strobe at edge N with FIFO empty -> word_valid=1 and word_data correct after edge N (visible in cycle N+1). The FIFO is first-word-fall-through.
- Handshake: a transfer occurs on an edge where word_valid & word_ready. word_data and word_valid hold stable while word_valid=1 and word_ready=0. word_ready while word_valid=0 has no effect.
- FIFO full rule: a push while full is accepted only if a pop occurs on the same edge. Otherwise the word is dropped and overflow sets and stays set until reset.
- Simultaneous push and pop at any level: fifo_level unchanged. Push and pop on an empty FIFO cannot coincide, because a pop requires word_valid.
- fifo_level = writes minus reads. Range 0..2**FIFO_AW.
- Timeout: the idle counter counts cycles with pack_cnt!=0 and no byte_valid. It clears on byte_valid or when pack_cnt=0. When it reaches TIMEOUT_CYC-1 and there is still no byte: pack_cnt is cleared, partial_drop pulses 1 cycle and the counter clears. A byte_valid on the timeout cycle wins: no drop, normal packing.
- Frame counting: word_cnt increments on each accepted transfer. On the transfer that makes word_cnt reach H_PIXEL*V_PIXEL, word_cnt returns to 0 and frame_done pulses 1 cycle after that edge. Packing and FIFO are unaffected by frame boundaries. Frame length is computed as a 24-bit constant.

Test Plan:
- Reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles with word_ready=1 -> word_valid 1 cycle after the 4th byte, word_data=0x44332211, word_cnt=1, fifo_level back to 0.
- word_ready=0, 16 full words pushed (FIFO_AW=4) -> fifo_level=16, overflow=0. A 17th word -> overflow=1, fifo_level=16. Then raise word_ready -> 16 words out in order, first word intact.
- Full FIFO, 4th byte of a new word arrives on the same edge as an accepted pop -> no overflow, fifo_level stays 16, new word appears last.
- Two bytes, then TIMEOUT_CYC idle cycles -> partial_drop pulses once, then 0xAA,0xBB,0xCC,0xDD -> word_data=0xDDCCBBAA, with no remnant of the first two bytes.
- H_PIXEL=4, V_PIXEL=2: 9 words streamed with word_ready=1 -> frame_done pulses once, after the 8th accepted word; word_cnt=1 after the 9th.
- sys_rst_n asserted after 3 bytes with 5 words queued -> all outputs 0 immediately. After release, 4 new bytes give exactly one word equal to those bytes.
